args_threshold_gen: RTL and testbench

Adaptive threshold generator for the pixel binarization stage. It accumulates the pixel stream of one frame, computes the mean pixel value with a multi-cycle divider, and adds a signed offset. It then clamps the result and publishes it as the threshold the binarizer uses on the next frame. It sits on the same pixel tap as the binarizer and drives that block's threshold input, replacing a static register value. The threshold changes only between frames, never mid-frame.

---
 rtl/args_pkg.sv | 29 ++
 rtl/args_udiv.sv | 66 ++++++
 rtl/args_threshold_gen.sv | 145 ++++++++++++++
 tb/tb_args_threshold_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/args_pkg.sv
// Shared types and helpers for the adaptive threshold path.
// The clamp is generic so other offset-adjusted config paths can reuse it.
package args_pkg;

  typedef enum logic [1:0] {
    ARGS_TG_IDLE   = 2'd0,
    ARGS_TG_ACCUM  = 2'd1,
    ARGS_TG_DIVIDE = 2'd2,
    ARGS_TG_UPDATE = 2'd3
  } args_tg_state_e;

  localparam int ARGS_CLAMP_W = 16;

  // Saturates a signed value into [0, 2^w-1]; w must not exceed ARGS_CLAMP_W.
  function automatic logic [ARGS_CLAMP_W-1:0] args_clamp(
    input logic signed [ARGS_CLAMP_W+1:0] val,
    input int unsigned                    w
  );
    logic signed [ARGS_CLAMP_W+1:0] hi;
    hi = (ARGS_CLAMP_W+2)'((1 << w) - 1);
    if (val < 0)
      return '0;
    else if (val > hi)
      return hi[ARGS_CLAMP_W-1:0];
    else
      return val[ARGS_CLAMP_W-1:0];
  endfunction

endpackage

// File: rtl/args_udiv.sv
// Sequential restoring divider, one quotient bit per cycle, QW cycles per divide.
// The caller guarantees num < den * 2^QW, so the upper bits seed the remainder.
module args_udiv #(
  parameter int NW = 32,
  parameter int DW = 22,
  parameter int QW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          done,
  output logic [QW-1:0] quo
);

  localparam int SW = $clog2(QW + 1);

  logic [DW-1:0] rem;
  logic [DW-1:0] den_r;
  logic [QW-1:0] nbits;
  logic [SW-1:0] steps;
  logic          run;
  logic [DW:0]   trial;
  logic          fits;

  always_comb begin
    trial = {rem, nbits[QW-1]};
    fits  = (trial >= {1'b0, den_r});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem   <= '0;
      den_r <= '0;
      nbits <= '0;
      quo   <= '0;
      steps <= '0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= DW'(num[NW-1:QW]);
        nbits <= num[QW-1:0];
        den_r <= den;
        quo   <= '0;
        steps <= SW'(QW);
        run   <= 1'b1;
      end else if (abort) begin
        run <= 1'b0;
      end else if (run) begin
        rem   <= fits ? DW'(trial - {1'b0, den_r}) : trial[DW-1:0];
        nbits <= nbits << 1;
        quo   <= {quo[QW-2:0], fits};
        steps <= steps - 1'b1;
        if (steps == SW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/args_threshold_gen.sv
// Adaptive binarization threshold: frame mean plus signed offset, clamped,
// published only between frames.
//   state  | meaning
//   IDLE   | waiting for an accepted start of frame
//   ACCUM  | summing valid pixels of the current frame
//   DIVIDE | divider computing floor(sum/cnt)
//   UPDATE | offset, clamp and publish the new threshold
module args_threshold_gen
  import args_pkg::*;
#(
  parameter int IW     = 10,
  parameter int CW     = 22,
  parameter int DEF_TH = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_sof,
  input  logic          in_valid,
  input  logic [IW-1:0] in,
  input  logic          in_eof,
  input  logic          cfg_en,
  input  logic [IW:0]   cfg_offset,
  output logic [IW-1:0] out_threshold,
  output logic          out_update,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  args_tg_state_e          state, state_nxt;
  logic [IW+CW-1:0]        sum, sum_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW:0]             off_r;
  logic                    new_frame, div_start, div_abort, div_done;
  logic                    load_off, do_update;
  logic [IW-1:0]           quo;
  logic signed [IW+1:0]    t_sum;
  logic signed [ARGS_CLAMP_W+1:0] t_ext;
  logic [IW-1:0]           th_new;

  args_udiv #(.NW(IW+CW), .DW(CW), .QW(IW)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .abort (div_abort),
    .num   (sum_nxt),
    .den   (cnt_nxt),
    .done  (div_done),
    .quo   (quo)
  );

  always_comb begin
    state_nxt = state;
    sum_nxt   = sum;
    cnt_nxt   = cnt;
    new_frame = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    load_off  = 1'b0;
    do_update = 1'b0;
    case (state)
      ARGS_TG_IDLE: begin
        if (in_sof && cfg_en) new_frame = 1'b1;
      end
      ARGS_TG_ACCUM: begin
        if (in_valid && in_eof) begin
          if (cnt != CNT_MAX) begin
            sum_nxt = sum + (IW+CW)'(in);
            cnt_nxt = cnt + 1'b1;
          end
          if (cnt_nxt != '0) begin
            state_nxt = ARGS_TG_DIVIDE;
            div_start = 1'b1;
          end else begin
            state_nxt = ARGS_TG_IDLE;
          end
        end else if (in_sof) begin
          new_frame = 1'b1;
        end else if (in_valid && cnt != CNT_MAX) begin
          sum_nxt = sum + (IW+CW)'(in);
          cnt_nxt = cnt + 1'b1;
        end
      end
      ARGS_TG_DIVIDE: begin
        if (in_sof) begin
          div_abort = 1'b1;
          state_nxt = ARGS_TG_IDLE;
          new_frame = cfg_en;
        end else if (div_done) begin
          state_nxt = ARGS_TG_UPDATE;
          load_off  = 1'b1;
        end
      end
      ARGS_TG_UPDATE: begin
        if (in_sof) begin
          div_abort = 1'b1;
          state_nxt = ARGS_TG_IDLE;
          new_frame = cfg_en;
        end else begin
          do_update = 1'b1;
          state_nxt = ARGS_TG_IDLE;
        end
      end
      default: state_nxt = ARGS_TG_IDLE;
    endcase
    // A new frame starts from the current pixel; a one-pixel frame goes straight to divide.
    if (new_frame) begin
      sum_nxt = in_valid ? (IW+CW)'(in) : '0;
      cnt_nxt = CW'(in_valid);
      if (in_valid && in_eof) begin
        state_nxt = ARGS_TG_DIVIDE;
        div_start = 1'b1;
      end else begin
        state_nxt = ARGS_TG_ACCUM;
      end
    end
  end

  always_comb begin
    t_sum  = $signed({2'b00, quo}) + $signed({off_r[IW], off_r});
    t_ext  = (ARGS_CLAMP_W+2)'(t_sum);
    th_new = IW'(args_clamp(t_ext, IW));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ARGS_TG_IDLE;
      sum           <= '0;
      cnt           <= '0;
      off_r         <= '0;
      out_threshold <= IW'(DEF_TH);
      out_update    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state      <= state_nxt;
      sum        <= sum_nxt;
      cnt        <= cnt_nxt;
      out_update <= do_update;
      busy       <= (state_nxt != ARGS_TG_IDLE);
      if (load_off)  off_r         <= cfg_offset;
      if (do_update) out_threshold <= th_new;
    end
  end

endmodule

// File: tb/tb_args_threshold_gen.sv
// Self-checking bench for args_threshold_gen: vector table of frames plus
// hand-written abort/restart/reset sequences, updates checked via a scoreboard.
module tb_args_threshold_gen;

  localparam int IW = 10;
  localparam int CW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_sof = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_eof = 1'b0;
  logic          cfg_en = 1'b0;
  logic [IW-1:0] in_pix = '0;
  logic [IW:0]   cfg_offset = '0;
  logic [IW-1:0] out_threshold;
  logic          out_update;
  logic          busy;

  args_threshold_gen #(.IW(IW), .CW(CW), .DEF_TH(512)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_sof        (in_sof),
    .in_valid      (in_valid),
    .in            (in_pix),
    .in_eof        (in_eof),
    .cfg_en        (cfg_en),
    .cfg_offset    (cfg_offset),
    .out_threshold (out_threshold),
    .out_update    (out_update),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int th;
    int edge_n;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int n;
    int pix[6];
    int off;
    bit gap;
    int exp_th;
  } vec_t;

  int errors = 0;
  int checks = 0;
  bit prev_upd = 1'b0;
  bit busy_seen = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (busy) busy_seen = 1'b1;
    if (out_update) begin
      if (sb.size() == 0) begin
        check("unexpected_update", 1, 0);
      end else begin
        e = sb.pop_front();
        check("threshold", int'(out_threshold), e.th);
        check("update_edge", cyc, e.edge_n);
        check("update_width", int'(prev_upd), 0);
      end
    end
    prev_upd = out_update;
  end

  task automatic cycle(input bit s, input bit v, input int p, input bit e);
    in_sof   = s;
    in_valid = v;
    in_pix   = IW'(p);
    in_eof   = e;
    @(posedge clk);
    #1;
    in_sof   = 1'b0;
    in_valid = 1'b0;
    in_eof   = 1'b0;
  endtask

  // Sof rides on the first pixel; gap cycles carry junk data and a stray eof with valid low.
  task automatic send_frame(input vec_t v, input bit push);
    exp_t e;
    for (int i = 0; i < v.n; i++) begin
      cycle(i == 0, 1'b1, v.pix[i], i == v.n - 1);
      if (v.gap && i < v.n - 1) cycle(1'b0, 1'b0, 999, 1'b1);
    end
    if (push) begin
      e.th     = v.exp_th;
      e.edge_n = cyc + IW + 2;
      sb.push_back(e);
    end
  endtask

  task automatic wait_update();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("update_timeout", sb.size(), 0);
    cycle(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    vec_t va, vb;
    vecs[0] = '{4, '{100, 200, 300, 400, 0, 0}, 0,     1'b0, 250};
    vecs[1] = '{4, '{100, 200, 300, 400, 0, 0}, -300,  1'b0, 0};
    vecs[2] = '{4, '{100, 200, 300, 400, 0, 0}, 900,   1'b0, 1023};
    vecs[3] = '{2, '{1, 2, 0, 0, 0, 0},         0,     1'b0, 1};
    vecs[4] = '{3, '{10, 20, 31, 0, 0, 0},      5,     1'b1, 25};
    vecs[5] = '{3, '{1023, 1023, 1023, 0, 0, 0}, -1023, 1'b0, 0};
    vecs[6] = '{1, '{7, 0, 0, 0, 0, 0},         3,     1'b0, 10};
    vecs[7] = '{2, '{1023, 1023, 0, 0, 0, 0},   1,     1'b0, 1023};

    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_threshold", int'(out_threshold), 512);
    check("reset_update", int'(out_update), 0);
    check("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b0, 1'b0, 0, 1'b0);

    // Adaptive mode disabled: the frame must be ignored entirely.
    cfg_en = 1'b0;
    busy_seen = 1'b0;
    send_frame(vecs[0], 1'b0);
    repeat (15) cycle(1'b0, 1'b0, 0, 1'b0);
    check("disabled_busy", int'(busy_seen), 0);
    check("disabled_threshold", int'(out_threshold), 512);

    cfg_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cfg_offset = (IW+1)'(vecs[i].off);
      send_frame(vecs[i], 1'b1);
      check("busy_in_divide", int'(busy), 1);
      wait_update();
      check("busy_after_update", int'(busy), 0);
    end

    // Next sof 5 cycles after eof aborts the pending divide.
    cfg_offset = '0;
    send_frame(vecs[0], 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 0, 1'b0);
    vb = '{2, '{40, 60, 0, 0, 0, 0}, 0, 1'b0, 50};
    send_frame(vb, 1'b1);
    check("abort_threshold_held", int'(out_threshold), 1023);
    wait_update();

    // Restart mid-frame: only pixels after the second sof count.
    cycle(1'b1, 1'b1, 500, 1'b0);
    cycle(1'b0, 1'b1, 600, 1'b0);
    va = '{2, '{10, 30, 0, 0, 0, 0}, 0, 1'b0, 20};
    send_frame(va, 1'b1);
    wait_update();

    // Reset during divide is immediate and the next frame is unaffected.
    send_frame(vecs[0], 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 0, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_div_threshold", int'(out_threshold), 512);
    check("rst_div_busy", int'(busy), 0);
    check("rst_div_update", int'(out_update), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b0, 1'b0, 0, 1'b0);
    send_frame(vecs[0], 1'b1);
    wait_update();

    repeat (20) cycle(1'b0, 1'b0, 0, 1'b0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
